// File: rtl/sd_photo_pkg.sv
// rtl/sd_photo_pkg.sv - shared constants, FSM state type and byte helper for the SD photo writer
package sd_photo_pkg;

    localparam int BMP_HDR_BYTES = 54;
    localparam int SEC_BYTES     = 512;
    localparam int WORDS_PER_SEC = 256;

    // BMP header field constants
    localparam int DIB_HDR_SIZE  = 40;
    localparam int BMP_BPP       = 24;
    localparam int BMP_PPM       = 2835;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEC_START,
        ST_WAIT_BUSY,
        ST_XFER,
        ST_WAIT_IDLE,
        ST_DONE
    } wp_state_e;

    // Little-endian byte k of a 32-bit header field
    function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] k);
        return v[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// rtl/bmp_header_rom.sv - combinational 54-byte BMP header lookup sized from IMG_W/IMG_H
module bmp_header_rom
    import sd_photo_pkg::*;
#(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 768
) (
    input  logic [5:0] idx,
    output logic [7:0] hdr_byte
);

    localparam logic [31:0] PIX_BYTES  = 32'(IMG_W * IMG_H * 3);
    localparam logic [31:0] TOT_BYTES  = 32'(BMP_HDR_BYTES) + PIX_BYTES;
    localparam logic [31:0] WIDTH_F    = 32'(IMG_W);
    // Negative height marks the bitmap top-down so SDRAM row order is kept
    localparam logic [31:0] HEIGHT_F   = 32'd0 - 32'(IMG_H);
    localparam logic [31:0] OFFSET_F   = 32'(BMP_HDR_BYTES);
    localparam logic [31:0] DIB_F      = 32'(DIB_HDR_SIZE);
    localparam logic [31:0] PPM_F      = 32'(BMP_PPM);

    // Byte lookup; fields not listed (reserved, compression, colour counts) read as zero
    always_comb begin
        hdr_byte = 8'h00;
        case (idx)
            6'd0:                       hdr_byte = 8'h42;
            6'd1:                       hdr_byte = 8'h4D;
            6'd2, 6'd3, 6'd4, 6'd5:     hdr_byte = le_byte(TOT_BYTES, 2'(idx - 6'd2));
            6'd10, 6'd11, 6'd12, 6'd13: hdr_byte = le_byte(OFFSET_F,  2'(idx - 6'd10));
            6'd14, 6'd15, 6'd16, 6'd17: hdr_byte = le_byte(DIB_F,     2'(idx - 6'd14));
            6'd18, 6'd19, 6'd20, 6'd21: hdr_byte = le_byte(WIDTH_F,   2'(idx - 6'd18));
            6'd22, 6'd23, 6'd24, 6'd25: hdr_byte = le_byte(HEIGHT_F,  2'(idx - 6'd22));
            6'd26:                      hdr_byte = 8'd1;
            6'd28:                      hdr_byte = 8'(BMP_BPP);
            6'd34, 6'd35, 6'd36, 6'd37: hdr_byte = le_byte(PIX_BYTES, 2'(idx - 6'd34));
            6'd38, 6'd39, 6'd40, 6'd41: hdr_byte = le_byte(PPM_F,     2'(idx - 6'd38));
            6'd42, 6'd43, 6'd44, 6'd45: hdr_byte = le_byte(PPM_F,     2'(idx - 6'd42));
            default:                    hdr_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/sd_write_photo.sv
// rtl/sd_write_photo.sv - SDRAM frame to SD card BMP writer; SD_WRITE_PHOTO_CHK_EN adds sticky err
module sd_write_photo
    import sd_photo_pkg::*;
#(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_sec_addr,
    output logic        sdram_rd_en,
    input  logic [15:0] sdram_rd_data,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        done
`ifdef SD_WRITE_PHOTO_CHK_EN
    ,
    output logic        err
`endif
);

    localparam int NPIX      = IMG_W * IMG_H;
    localparam int PIX_BYTES = NPIX * 3;
    localparam int TOT_BYTES = BMP_HDR_BYTES + PIX_BYTES;
    localparam int SEC_NUM   = (TOT_BYTES + SEC_BYTES - 1) / SEC_BYTES;
    localparam int PCW       = $clog2(NPIX + 1);
    localparam int SCW       = $clog2(SEC_NUM + 1);
    localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_SEC - 1);

    wp_state_e        state_q, state_d;
    logic [31:0]      sec_ptr_q, sec_ptr_d;
    logic [SCW-1:0]   sec_cnt_q, sec_cnt_d;
    logic [7:0]       word_cnt_q, word_cnt_d;
    logic             wr_start_en_q, wr_start_en_d;
    logic [31:0]      wr_sec_addr_q, wr_sec_addr_d;
    logic [15:0]      wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Byte queue: byte 0 (oldest) in the low bits, unused slots kept zero
    logic [47:0]      q_q, q_d;
    logic [2:0]       qcnt_q, qcnt_d;
    logic [5:0]       hdr_idx_q, hdr_idx_d;
    logic [PCW-1:0]   pix_cnt_q, pix_cnt_d;
    logic             rd_en_q, rd_en_d;
    logic             pend_q, pend_d;

    logic             load, sec_adv, word_ev;
    logic             filling, hdr_done, pix_left, rd_idle;
    logic             hdr_push, rd_issue, pad_push, pop;
    logic [7:0]       hdr_byte;
    logic [23:0]      push_vec;
    logic [2:0]       push_n;
    logic [2:0]       base;
    logic [47:0]      q_shift;

    bmp_header_rom #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_hdr (
        .idx      (hdr_idx_q),
        .hdr_byte (hdr_byte)
    );

    assign word_ev = (state_q == ST_XFER) && wr_req;

    // Sector sequencing: next state and control strobes
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        sec_adv = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SEC_START;
                end
            end
            ST_SEC_START: state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (wr_busy) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (word_ev && (word_cnt_q == LAST_WORD)) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (!wr_busy) begin
                    sec_adv = 1'b1;
                    state_d = (sec_cnt_q == SCW'(SEC_NUM - 1)) ? ST_DONE : ST_SEC_START;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sector pointer, counters and registered handshake outputs
    always_comb begin
        sec_ptr_d     = sec_ptr_q;
        sec_cnt_d     = sec_cnt_q;
        word_cnt_d    = word_cnt_q;
        wr_sec_addr_d = wr_sec_addr_q;
        if (load) begin
            sec_ptr_d = start_sec_addr;
            sec_cnt_d = '0;
        end else if (sec_adv) begin
            sec_ptr_d = sec_ptr_q + 32'd1;
            sec_cnt_d = sec_cnt_q + SCW'(1);
        end
        if (state_q == ST_SEC_START) begin
            word_cnt_d = 8'd0;
        end else if (word_ev) begin
            word_cnt_d = word_cnt_q + 8'd1;
        end
        wr_start_en_d = (state_d == ST_SEC_START);
        if (state_d == ST_SEC_START) begin
            wr_sec_addr_d = sec_ptr_d;
        end
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // Byte queue filling (header, pixels, zero padding) and draining into wr_data
    always_comb begin
        filling  = (state_q == ST_SEC_START) || (state_q == ST_WAIT_BUSY) ||
                   (state_q == ST_XFER)      || (state_q == ST_WAIT_IDLE);
        hdr_done = (hdr_idx_q == 6'(BMP_HDR_BYTES));
        pix_left = (pix_cnt_q != PCW'(NPIX));
        rd_idle  = !rd_en_q && !pend_q;
        // Header and padding only push while no pixel read is in flight, so the
        // 3-byte space reserved at issue is still free when the pixel lands
        hdr_push = filling && !hdr_done && (qcnt_q <= 3'd5) && !pend_q;
        rd_issue = filling && hdr_done && pix_left && rd_idle && (qcnt_q <= 3'd3);
        pad_push = filling && hdr_done && !pix_left && rd_idle && (qcnt_q <= 3'd4);
        pop      = word_ev && (qcnt_q >= 3'd2);

        q_shift  = pop ? (q_q >> 16) : q_q;
        base     = pop ? (qcnt_q - 3'd2) : qcnt_q;

        push_vec = 24'h0;
        push_n   = 3'd0;
        if (pend_q) begin
            // RGB565 to BGR888: widen each channel by repeating its top bits
            push_vec = {sdram_rd_data[15:11], sdram_rd_data[15:13],
                        sdram_rd_data[10:5],  sdram_rd_data[10:9],
                        sdram_rd_data[4:0],   sdram_rd_data[4:2]};
            push_n   = 3'd3;
        end else if (hdr_push) begin
            push_vec = {16'h0, hdr_byte};
            push_n   = 3'd1;
        end else if (pad_push) begin
            push_n   = 3'd2;
        end

        q_d       = q_shift | ({24'h0, push_vec} << {base, 3'b000});
        qcnt_d    = base + push_n;
        hdr_idx_d = hdr_push ? (hdr_idx_q + 6'd1) : hdr_idx_q;
        pix_cnt_d = rd_issue ? (pix_cnt_q + PCW'(1)) : pix_cnt_q;
        rd_en_d   = rd_issue;
        pend_d    = rd_en_q;
        if (load) begin
            q_d       = '0;
            qcnt_d    = 3'd0;
            hdr_idx_d = 6'd0;
            pix_cnt_d = '0;
        end

        wr_data_d = wr_data_q;
        if (word_ev) begin
            wr_data_d = pop ? {q_q[7:0], q_q[15:8]} : 16'h0000;
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sec_ptr_q     <= 32'd0;
            sec_cnt_q     <= '0;
            word_cnt_q    <= 8'd0;
            wr_start_en_q <= 1'b0;
            wr_sec_addr_q <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sec_ptr_q     <= sec_ptr_d;
            sec_cnt_q     <= sec_cnt_d;
            word_cnt_q    <= word_cnt_d;
            wr_start_en_q <= wr_start_en_d;
            wr_sec_addr_q <= wr_sec_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Datapath registers: queue, fetch bookkeeping and output word
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= 48'h0;
            qcnt_q    <= 3'd0;
            hdr_idx_q <= 6'd0;
            pix_cnt_q <= '0;
            rd_en_q   <= 1'b0;
            pend_q    <= 1'b0;
            wr_data_q <= 16'h0000;
        end else begin
            q_q       <= q_d;
            qcnt_q    <= qcnt_d;
            hdr_idx_q <= hdr_idx_d;
            pix_cnt_q <= pix_cnt_d;
            rd_en_q   <= rd_en_d;
            pend_q    <= pend_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign sdram_rd_en = rd_en_q;
    assign wr_start_en = wr_start_en_q;
    assign wr_sec_addr = wr_sec_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef SD_WRITE_PHOTO_CHK_EN
    logic err_q;

    // Sticky flag for a word request the queue cannot serve or that arrives outside a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            if (wr_req && ((state_q != ST_XFER) || (qcnt_q < 3'd2))) begin
                err_q <= 1'b1;
            end
            assert (!(wr_req && ((state_q != ST_XFER) || (qcnt_q < 3'd2))))
                else $error("sd_write_photo: wr_req outside XFER or byte queue underflow");
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_sd_write_photo.sv
// tb/tb_sd_write_photo.sv - randomized self-checking bench for sd_write_photo against a byte-stream model
module tb_sd_write_photo;

    localparam int W      = 16;
    localparam int H      = 12;
    localparam int NPIX   = W * H;
    localparam int PIXB   = NPIX * 3;
    localparam int TOT    = 54 + PIXB;
    localparam int NSEC   = (TOT + 511) / 512;
    localparam int NWORDS = NSEC * 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_sec_addr;
    logic        sdram_rd_en;
    logic [15:0] sdram_rd_data;
    logic        wr_start_en;
    logic [31:0] wr_sec_addr;
    logic        wr_busy;
    logic        wr_req;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
`ifdef SD_WRITE_PHOTO_CHK_EN
    logic        err;
`endif

    sd_write_photo #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_sec_addr (start_sec_addr),
        .sdram_rd_en    (sdram_rd_en),
        .sdram_rd_data  (sdram_rd_data),
        .wr_start_en    (wr_start_en),
        .wr_sec_addr    (wr_sec_addr),
        .wr_busy        (wr_busy),
        .wr_req         (wr_req),
        .wr_data        (wr_data),
        .busy           (busy),
        .done           (done)
`ifdef SD_WRITE_PHOTO_CHK_EN
        ,
        .err            (err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] pix_mem   [NPIX];
    logic [7:0]  exp_bytes [NWORDS*2];
    logic [15:0] got_words [NWORDS];
    logic [31:0] base_addr;

    int n_start = 0, n_rd = 0, n_done = 0;
    int sup_cnt = 0;
    int sup_base = 0;
    int start_base, rd_base, done_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (wr_start_en) n_start++;
        if (sdram_rd_en) n_rd++;
        if (done)        n_done++;
    end

    // SDRAM FIFO model: data for a read appears the cycle after sdram_rd_en
    initial begin
        sdram_rd_data = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (sdram_rd_en) begin
                if (sup_cnt - sup_base < NPIX) sdram_rd_data = pix_mem[sup_cnt - sup_base];
                else sdram_rd_data = 16'h0;
                sup_cnt++;
            end
        end
    end

    task automatic put32(input int off, input logic [31:0] v);
        for (int k = 0; k < 4; k++) exp_bytes[off + k] = 8'(v >> (8 * k));
    endtask

    // Expected BMP byte image: header fields, BGR888 pixels, zero fill to the sector end
    task automatic build_expected();
        int r5, g6, b5;
        for (int i = 0; i < NWORDS * 2; i++) exp_bytes[i] = 8'h00;
        exp_bytes[0] = "B";
        exp_bytes[1] = "M";
        put32(2, TOT);
        put32(10, 54);
        put32(14, 40);
        put32(18, W);
        put32(22, -H);
        exp_bytes[26] = 8'd1;
        exp_bytes[28] = 8'd24;
        put32(34, PIXB);
        put32(38, 2835);
        put32(42, 2835);
        for (int p = 0; p < NPIX; p++) begin
            r5 = int'(pix_mem[p]) / 2048;
            g6 = (int'(pix_mem[p]) / 32) % 64;
            b5 = int'(pix_mem[p]) % 32;
            exp_bytes[54 + 3*p]     = 8'(b5 * 8 + b5 / 4);
            exp_bytes[54 + 3*p + 1] = 8'(g6 * 4 + g6 / 16);
            exp_bytes[54 + 3*p + 2] = 8'(r5 * 8 + r5 / 4);
        end
    endtask

    function automatic logic [15:0] exp_word(input int i);
        return {exp_bytes[2*i], exp_bytes[2*i + 1]};
    endfunction

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wr_start_en) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // SD controller model for one sector; optionally resets mid-sector or pokes start
    task automatic serve_sector(input int s, input int abort_at, input bit inject, output bit aborted);
        aborted = 1'b0;
        check($sformatf("sec_addr%0d", s), wr_sec_addr, base_addr + 32'(s));
        tick();
        tick();
        wr_busy = 1'b1;
        for (int w = 0; w < 256; w++) begin
            if (w == abort_at) begin
                rst = 1'b1;
                tick();
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_wr_start_en", wr_start_en, 1'b0);
                check("rst_sdram_rd_en", sdram_rd_en, 1'b0);
                check("rst_wr_sec_addr", wr_sec_addr, 32'h0);
                check("rst_wr_data", wr_data, 16'h0);
                wr_busy = 1'b0;
                aborted = 1'b1;
                return;
            end
            if (inject && w == 4) begin
                start_sec_addr = 32'h0000_DEAD;
                start = 1'b1;
                tick();
                start = 1'b0;
                start_sec_addr = base_addr;
            end
            repeat ($urandom_range(8, 11)) tick();
            wr_req = 1'b1;
            tick();
            wr_req = 1'b0;
            got_words[s*256 + w] = wr_data;
            check($sformatf("word%0d", s*256 + w), wr_data, exp_word(s*256 + w));
        end
        repeat (3) tick();
        if (s == NSEC - 1) check("done_before_idle", n_done - done_base, 0);
        wr_busy = 1'b0;
    endtask

    task automatic run_capture(input logic [31:0] addr, input int abort_sec, input int abort_word,
                               input bit inject, output bit aborted);
        bit ok;
        aborted    = 1'b0;
        base_addr  = addr;
        start_base = n_start;
        rd_base    = n_rd;
        done_base  = n_done;
        sup_base   = sup_cnt;
        build_expected();
        start_sec_addr = addr;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        for (int s = 0; s < NSEC; s++) begin
            wait_start(ok);
            if (!ok) begin
                check("start_timeout", 0, 1);
                return;
            end
            serve_sector(s, (s == abort_sec) ? abort_word : -1, inject && (s == 0), aborted);
            if (aborted) return;
        end
        wait_done(ok);
        check("done_seen", ok, 1'b1);
        check("busy_at_done", busy, 1'b0);
        tick();
        check("done_one_cycle", done, 1'b0);
        check("sector_writes", n_start - start_base, NSEC);
        check("sdram_reads", n_rd - rd_base, NPIX);
        check("done_pulses", n_done - done_base, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit aborted;
        int s0, r0;
        rst = 1'b1;
        start = 1'b0;
        start_sec_addr = 32'h0;
        wr_busy = 1'b0;
        wr_req = 1'b0;
        repeat (3) tick();
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_wr_start_en", wr_start_en, 1'b0);
        check("reset_sdram_rd_en", sdram_rd_en, 1'b0);
        check("reset_wr_sec_addr", wr_sec_addr, 32'h0);
        check("reset_wr_data", wr_data, 16'h0);
        rst = 1'b0;
        tick();

        // Run 1: known leading pixels, start poked while busy
        for (int i = 0; i < NPIX; i++) pix_mem[i] = 16'($urandom);
        pix_mem[0] = 16'hF800;
        pix_mem[1] = 16'h07E0;
        pix_mem[2] = 16'h001F;
        pix_mem[3] = 16'hFFFF;
        run_capture(32'd100, -1, -1, 1'b1, aborted);
        check("w0_magic", got_words[0], 16'h424D);
        check("w1_size_lo", got_words[1], 16'h7602);
        check("w2_size_hi", got_words[2], 16'h0000);
        check("w11_height_lo", got_words[11], 16'hF4FF);
        check("w27_pix", got_words[27], 16'h0000);
        check("w28_pix", got_words[28], 16'hFF00);
        check("w29_pix", got_words[29], 16'hFF00);
        check("w_last_pad", got_words[NWORDS-1], 16'h0000);
        tick();

        // Run 2: reset during the second sector's transfer
        for (int i = 0; i < NPIX; i++) pix_mem[i] = 16'($urandom);
        run_capture(32'($urandom_range(1000, 100000)), 1, 20, 1'b0, aborted);
        check("aborted", aborted, 1'b1);
        tick();
        rst = 1'b0;
        s0 = n_start;
        r0 = n_rd;
        repeat (40) tick();
        check("no_start_after_rst", n_start - s0, 0);
        check("no_read_after_rst", n_rd - r0, 0);
        check("idle_after_rst", busy, 1'b0);

        // Run 3: fresh capture, sector pointer wraps past 0xFFFFFFFF
        for (int i = 0; i < NPIX; i++) pix_mem[i] = 16'($urandom);
        run_capture(32'hFFFF_FFFF, -1, -1, 1'b0, aborted);
        check("rerun_magic", got_words[0], 16'h424D);

`ifdef SD_WRITE_PHOTO_CHK_EN
        tick();
        check("err_clear", err, 1'b0);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        check("err_set", err, 1'b1);
        repeat (5) tick();
        check("err_sticky", err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_reset", err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_write_photo.md
Name: sd_write_photo

Overview:
- Dumps a frame held in SDRAM to the SD card as a 24-bpp BMP file at a given start sector.
- Pulls RGB565 pixels from the SDRAM controller FIFO read port and expands them to BGR888.
- Prepends a 54-byte BMP header and packs the byte stream into 16-bit words for the SD controller's sector-write interface (wr_start_en / wr_sec_addr / wr_busy / wr_req / wr_data).
- Sits between the SDRAM controller read port and the SD card controller: the write-side counterpart of the photo reader.

Parameters:
- IMG_W, 1024: image width in pixels; must be a multiple of 4 so rows need no padding.
- IMG_H, 768: image height in pixels.
- Derived localparams:
  - PIX_BYTES = IMG_W*IMG_H*3
  - TOT_BYTES = 54+PIX_BYTES
  - SEC_NUM = ceil(TOT_BYTES/512); 4609 at the defaults.

Ports:
- clk  in  1  block clock (50 MHz SD domain); only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a capture when idle.
- start_sec_addr  in  32  first SD sector of the file; sampled on start.
- sdram_rd_en  out  1  SDRAM FIFO read request; data valid one cycle later.
- sdram_rd_data  in  16  RGB565 pixel {R5,G6,B5}.
- wr_start_en  out  1  one-cycle pulse requesting a 512-byte sector write.
- wr_sec_addr  out  32  sector address; valid with wr_start_en and held until the next one.
- wr_busy  in  1  SD controller is writing a sector.
- wr_req  in  1  SD controller wants the next 16-bit word.
- wr_data  out  16  data word; first stream byte in [15:8].
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the last sector completes.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters and the byte queue cleared.
- Reset mid-operation aborts immediately. No further wr_start_en or sdram_rd_en is issued.
- FSM states: IDLE, SEC_START, WAIT_BUSY, XFER, WAIT_IDLE, DONE.
  - IDLE: on start, latch start_sec_addr into the sector pointer, clear counters, set busy, go to SEC_START. start is ignored while busy.
  - SEC_START: wr_start_en=1 for one cycle, wr_sec_addr = pointer; go to WAIT_BUSY.
  - WAIT_BUSY: wait for wr_busy=1, then go to XFER.
  - XFER: each wr_req high pops 2 bytes from the byte queue into wr_data, registered. wr_data changes the cycle after wr_req and holds until the next wr_req. After 256 words go to WAIT_IDLE.
  - WAIT_IDLE: wait for wr_busy=0. Then increment the pointer and sector count. If count == SEC_NUM go to DONE, else go to SEC_START.
  - DONE: done=1 for one cycle, busy cleared, back to IDLE.
- Byte stream, in order:
  - Header bytes 0..53 first.
  - Then pixels as B8, G8, R8 with B8={B5,B5[4:2]}, G8={G6,G6[5:4]}, R8={R5,R5[4:2]}.
  - Then 0x00 padding to the sector end once PIX_BYTES pixel bytes are emitted.
- Header contents, all multi-byte fields little-endian:
  - "BM"; bfSize = TOT_BYTES; reserved 0; offset 54.
  - DIB size 40; width IMG_W; height = -IMG_H as 32-bit two's complement (top-down, so SDRAM order is preserved).
  - planes 1; bpp 24; compression 0; image size PIX_BYTES; xppm = yppm = 2835; colors 0, 0.
- Byte queue: 6-byte capacity.
  - The fetcher asserts sdram_rd_en for one cycle when free space ≥3, pixels remain, and no read is outstanding. It pushes 3 bytes the following cycle.
  - The queue must hold ≥2 bytes before each wr_req. Prefetch starts in SEC_START, and wr_req spacing is ≥8 clk cycles.
  - Underflow is a design error, flagged under the optional feature.
- Pixel counter width is $clog2(IMG_W*IMG_H+1). No SDRAM read is issued past IMG_W*IMG_H pixels.

Optional Feature:
- SD_WRITE_PHOTO_CHK_EN defined:
  - Adds a sticky output err (1 bit, reset 0). It is set on queue underflow at wr_req, or on wr_req outside XFER.
  - Adds a simulation assertion for the same conditions.
- Undefined: no err port and no checking logic.

Decomposition:
- Shared package sd_photo_pkg:
  - BMP_HDR_BYTES=54, SEC_BYTES=512, WORDS_PER_SEC=256.
  - FSM state enum.
  - Header field constants (DIB size 40, bpp 24, ppm 2835).
- Sub-module bmp_header_rom: combinational 54-entry byte lookup indexed 0..53, computing size fields from IMG_W/IMG_H.

Test Plan:
- IMG_W=4, IMG_H=2, start_sec_addr=100: exactly one wr_start_en, with wr_sec_addr=100.
  - Words 0..2 = 0x424D, 0x4E00, 0x0000.
  - Header word 11 (height low half) = 0xFEFF.
  - done pulses once after wr_busy falls.
- Same config, pixels 0xF800, 0x07E0, 0x001F, 0xFFFF...: word 27 = 0x0000, word 28 = 0xFF00, word 29 = 0xFF00.
  - Remaining bytes after pixel data are 0x00 through word 255.
  - Exactly 8 sdram_rd_en pulses.
- Default 1024x768: 4609 sector writes with addresses start..start+4608, and 786432 sdram_rd_en pulses.
- Assert start while busy: ignored; sector count and addresses unchanged.
- Assert rst during XFER of sector 1: all outputs 0 next cycle and no further wr_start_en. A new start rewrites from start_sec_addr with header word 0x424D.
- With SD_WRITE_PHOTO_CHK_EN, inject wr_req in IDLE: err=1 and stays set until rst.
